// File: rtl/bp_sram_pkg.sv
// Shared constants for the logic-analyzer SRAM port arbiter: requester indices,
// owner encodings, arbiter states and the pin levels driven while the port is unowned.
package bp_sram_pkg;

  localparam int REQ_CAPTURE  = 0;
  localparam int REQ_READBACK = 1;
  localparam int REQ_DEBUG    = 2;
  localparam int NUM_REQ      = 3;

  localparam logic [1:0] OWNER_NONE     = 2'd0;
  localparam logic [1:0] OWNER_CAPTURE  = 2'd1;
  localparam logic [1:0] OWNER_READBACK = 2'd2;
  localparam logic [1:0] OWNER_DEBUG    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam logic IDLE_CS     = 1'b1;
  localparam logic IDLE_CLOCK  = 1'b0;
  localparam logic IDLE_SIO_O  = 1'b0;
  localparam logic IDLE_SIO_OE = 1'b0;

  // Owner code 1..3 maps onto grant bit 0..2; OWNER_NONE gives no grant.
  function automatic logic [NUM_REQ-1:0] owner_gnt(input logic [1:0] o);
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (o != OWNER_NONE) g[o - 2'd1] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/sram_hold_timer.sv
// Clear/enable cycle counter; expire pulses on the LIMIT-th consecutive enabled
// cycle since the last clear, which lets the arbiter leave its state on that edge.
module sram_hold_timer #(
  parameter int LIMIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Grants the shared LA SRAM port to capture, readback or debug, muxes the owner's
// pin drive onto the SRAM pads, holds CS high between owners and revokes long holds.
module sram_port_arbiter
  import bp_sram_pkg::*;
#(
  parameter int LA_WIDTH     = 8,
  parameter int LA_CHIPS     = 2,
  parameter int GUARD_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic [NUM_REQ*LA_CHIPS-1:0]  rq_cs,
  input  logic [NUM_REQ*LA_CHIPS-1:0]  rq_sclk,
  input  logic [NUM_REQ*LA_WIDTH-1:0]  rq_sio_o,
  input  logic [NUM_REQ*LA_WIDTH-1:0]  rq_sio_oe,
  output logic [LA_CHIPS-1:0]          sram_cs,
  output logic [LA_CHIPS-1:0]          sram_clock,
  output logic [LA_WIDTH-1:0]          sram_sio_o,
  output logic [LA_WIDTH-1:0]          sram_sio_oe,
  output logic                         busy,
  output logic [1:0]                   owner,
  output logic                         abort,
  input  logic                         abort_clr
);

  arb_state_t state, state_next;
  logic [1:0] owner_next;
  logic       owner_req;
  logic       hold_enable, hold_expire;
  logic       guard_enable, guard_expire;
  logic       revoke;

  always_comb begin
    owner_req = 1'b0;
    case (owner)
      OWNER_CAPTURE:  owner_req = req[REQ_CAPTURE];
      OWNER_READBACK: owner_req = req[REQ_READBACK];
      OWNER_DEBUG:    owner_req = req[REQ_DEBUG];
      default:        owner_req = 1'b0;
    endcase
  end

  // Owner still holding while capture waits; an owner dropping req never counts,
  // so a drop on the expiring cycle is an ordinary release.
  assign hold_enable  = (state == ST_OWN) && owner_req &&
                        (owner != OWNER_CAPTURE) && req[REQ_CAPTURE];
  assign guard_enable = (state == ST_GUARD);
  assign revoke       = hold_expire;

  sram_hold_timer #(.LIMIT(HOLD_TIMEOUT)) u_hold_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!hold_enable),
    .enable (hold_enable),
    .expire (hold_expire)
  );

  sram_hold_timer #(.LIMIT(GUARD_CYCLES)) u_guard_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!guard_enable),
    .enable (guard_enable),
    .expire (guard_expire)
  );

  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      ST_IDLE: begin
        if (req[REQ_CAPTURE]) begin
          state_next = ST_OWN;
          owner_next = OWNER_CAPTURE;
        end else if (req[REQ_READBACK]) begin
          state_next = ST_OWN;
          owner_next = OWNER_READBACK;
        end else if (req[REQ_DEBUG]) begin
          state_next = ST_OWN;
          owner_next = OWNER_DEBUG;
        end
      end
      ST_OWN: begin
        if (!owner_req || revoke) begin
          state_next = ST_GUARD;
          owner_next = OWNER_NONE;
        end
      end
      ST_GUARD: begin
        if (guard_expire) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        owner_next = OWNER_NONE;
      end
    endcase
  end

  // A revoke on the same edge as abort_clr wins so the event is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      owner <= OWNER_NONE;
      gnt   <= '0;
      busy  <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      gnt   <= owner_gnt(owner_next);
      busy  <= (state_next != ST_IDLE);
      if (revoke)         abort <= 1'b1;
      else if (abort_clr) abort <= 1'b0;
    end
  end

  always_comb begin
    sram_cs     = {LA_CHIPS{IDLE_CS}};
    sram_clock  = {LA_CHIPS{IDLE_CLOCK}};
    sram_sio_o  = {LA_WIDTH{IDLE_SIO_O}};
    sram_sio_oe = {LA_WIDTH{IDLE_SIO_OE}};
    case (owner)
      OWNER_CAPTURE: begin
        sram_cs     = rq_cs[REQ_CAPTURE*LA_CHIPS +: LA_CHIPS];
        sram_clock  = rq_sclk[REQ_CAPTURE*LA_CHIPS +: LA_CHIPS];
        sram_sio_o  = rq_sio_o[REQ_CAPTURE*LA_WIDTH +: LA_WIDTH];
        sram_sio_oe = rq_sio_oe[REQ_CAPTURE*LA_WIDTH +: LA_WIDTH];
      end
      OWNER_READBACK: begin
        sram_cs     = rq_cs[REQ_READBACK*LA_CHIPS +: LA_CHIPS];
        sram_clock  = rq_sclk[REQ_READBACK*LA_CHIPS +: LA_CHIPS];
        sram_sio_o  = rq_sio_o[REQ_READBACK*LA_WIDTH +: LA_WIDTH];
        sram_sio_oe = rq_sio_oe[REQ_READBACK*LA_WIDTH +: LA_WIDTH];
      end
      OWNER_DEBUG: begin
        sram_cs     = rq_cs[REQ_DEBUG*LA_CHIPS +: LA_CHIPS];
        sram_clock  = rq_sclk[REQ_DEBUG*LA_CHIPS +: LA_CHIPS];
        sram_sio_o  = rq_sio_o[REQ_DEBUG*LA_WIDTH +: LA_WIDTH];
        sram_sio_oe = rq_sio_oe[REQ_DEBUG*LA_WIDTH +: LA_WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a random run
// compared every cycle against a behavioural ownership model.
module tb_sram_port_arbiter;

  localparam int W = 8;
  localparam int C = 2;
  localparam int G = 2;
  localparam int H = 8;

  logic            clock;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      gnt;
  logic [3*C-1:0]  rq_cs;
  logic [3*C-1:0]  rq_sclk;
  logic [3*W-1:0]  rq_sio_o;
  logic [3*W-1:0]  rq_sio_oe;
  logic [C-1:0]    sram_cs;
  logic [C-1:0]    sram_clock;
  logic [W-1:0]    sram_sio_o;
  logic [W-1:0]    sram_sio_oe;
  logic            busy;
  logic [1:0]      owner;
  logic            abort;
  logic            abort_clr;

  int checks = 0;
  int errors = 0;

  // Model: who owns the port, guard cycles left, hold cycles counted, sticky abort.
  int m_owner;
  int m_guard;
  int m_hold;
  bit m_abort;

  sram_port_arbiter #(
    .LA_WIDTH(W), .LA_CHIPS(C), .GUARD_CYCLES(G), .HOLD_TIMEOUT(H)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt),
    .rq_cs(rq_cs), .rq_sclk(rq_sclk), .rq_sio_o(rq_sio_o), .rq_sio_oe(rq_sio_oe),
    .sram_cs(sram_cs), .sram_clock(sram_clock), .sram_sio_o(sram_sio_o),
    .sram_sio_oe(sram_sio_oe), .busy(busy), .owner(owner), .abort(abort),
    .abort_clr(abort_clr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    m_owner = 0;
    m_guard = 0;
    m_hold  = 0;
    m_abort = 0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic clr);
    bit revoked;
    revoked = 0;
    if (m_guard > 0) begin
      m_guard--;
    end else if (m_owner == 0) begin
      m_hold = 0;
      if (r[0]) m_owner = 1;
      else if (r[1]) m_owner = 2;
      else if (r[2]) m_owner = 3;
    end else if (!r[m_owner-1]) begin
      m_owner = 0;
      m_guard = G;
    end else if (m_owner != 1 && r[0]) begin
      m_hold++;
      if (m_hold == H) begin
        revoked = 1;
        m_owner = 0;
        m_guard = G;
      end
    end else begin
      m_hold = 0;
    end
    if (revoked) m_abort = 1;
    else if (clr) m_abort = 0;
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step(req, abort_clr);
    @(negedge clock);
  endtask

  task automatic apply_stimulus_pins();
    rq_cs     = 6'($urandom);
    rq_sclk   = 6'($urandom);
    rq_sio_o  = 24'($urandom);
    rq_sio_oe = 24'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; abort_clr = 1'b0;
    apply_stimulus_pins();
    model_reset();
    cycle(); cycle();
    checks++;
    if (gnt !== 3'b000 || owner !== 2'd0 || busy !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: gnt=%b owner=%0d busy=%b abort=%b required 000/0/0/0", gnt, owner, busy, abort);
    end
    checks++;
    if (sram_cs !== 2'b11 || sram_clock !== 2'b00 || sram_sio_o !== 8'h00 || sram_sio_oe !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pins: cs=%b clk=%b sio_o=%h oe=%h required 11/00/00/00", sram_cs, sram_clock, sram_sio_o, sram_sio_oe);
    end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_single_debug();
    rq_cs = 6'b10_00_01;
    req = 3'b100;
    cycle();
    checks++;
    if (gnt !== 3'b100 || owner !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL debug_grant: gnt=%b owner=%0d busy=%b required 100/3/1", gnt, owner, busy);
    end
    checks++;
    if (sram_cs !== 2'b10) begin
      errors++;
      $display("[TB] FAIL debug_cs: got %b required 10", sram_cs);
    end
    for (int i = 0; i < 8; i++) cycle();
    req = 3'b000;
    cycle();
    checks++;
    if (sram_cs !== 2'b11 || gnt !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL debug_release: cs=%b gnt=%b busy=%b required 11/000/1", sram_cs, gnt, busy);
    end
    for (int i = 1; i < G; i++) begin
      cycle();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL guard_busy: got %b required 1 at guard cycle %0d", busy, i);
      end
    end
    cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL guard_end: busy got %b required 0", busy);
    end
  endtask

  task automatic test_priority();
    int gap;
    req = 3'b111;
    cycle();
    checks++;
    if (gnt !== 3'b001 || owner !== 2'd1) begin
      errors++;
      $display("[TB] FAIL prio_first: gnt=%b owner=%0d required 001/1", gnt, owner);
    end
    cycle(); cycle();
    req = 3'b110;
    cycle();
    gap = 0;
    while (gnt === 3'b000 && gap < 20) begin
      cycle();
      gap++;
    end
    checks++;
    if (gnt !== 3'b010 || gap != G + 1) begin
      errors++;
      $display("[TB] FAIL prio_readback: gnt=%b after %0d cycles required 010 after %0d", gnt, gap, G + 1);
    end
    req = 3'b100;
    cycle();
    gap = 0;
    while (gnt === 3'b000 && gap < 20) begin
      cycle();
      gap++;
    end
    checks++;
    if (gnt !== 3'b100 || gap != G + 1) begin
      errors++;
      $display("[TB] FAIL prio_debug: gnt=%b after %0d cycles required 100 after %0d", gnt, gap, G + 1);
    end
  endtask

  task automatic test_timeout();
    req = 3'b000;
    for (int i = 0; i <= G; i++) cycle();
    req = 3'b010;
    cycle();
    req = 3'b011;
    for (int i = 1; i < H; i++) begin
      cycle();
      checks++;
      if (gnt !== 3'b010 || abort !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_keep: cycle %0d gnt=%b abort=%b required 010/0", i, gnt, abort);
      end
    end
    cycle();
    checks++;
    if (gnt !== 3'b000 || abort !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_revoke: gnt=%b abort=%b busy=%b required 000/1/1", gnt, abort, busy);
    end
    for (int i = 0; i < G; i++) cycle();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL revoke_guard: gnt=%b busy=%b required 000/0", gnt, busy);
    end
    cycle();
    checks++;
    if (gnt !== 3'b001 || owner !== 2'd1) begin
      errors++;
      $display("[TB] FAIL revoke_capture: gnt=%b owner=%0d required 001/1", gnt, owner);
    end
    abort_clr = 1'b1;
    cycle();
    abort_clr = 1'b0;
    checks++;
    if (abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_clr: got %b required 0", abort);
    end
  endtask

  task automatic test_drop_at_timeout();
    req = 3'b000;
    for (int i = 0; i <= G; i++) cycle();
    req = 3'b010;
    cycle();
    req = 3'b011;
    for (int i = 1; i < H; i++) cycle();
    req = 3'b001;
    cycle();
    checks++;
    if (gnt !== 3'b000 || abort !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_timeout: gnt=%b abort=%b busy=%b required 000/0/1", gnt, abort, busy);
    end
    for (int i = 0; i <= G; i++) cycle();
    checks++;
    if (gnt !== 3'b001 || abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_regrant: gnt=%b abort=%b required 001/0", gnt, abort);
    end
  endtask

  task automatic test_async_reset();
    rq_cs     = 6'b11_11_00;
    rq_sio_o  = 24'h0000A5;
    rq_sio_oe = 24'h0000FF;
    #1;
    checks++;
    if (sram_sio_oe !== 8'hFF || sram_cs !== 2'b00) begin
      errors++;
      $display("[TB] FAIL pre_reset_pins: oe=%h cs=%b required ff/00", sram_sio_oe, sram_cs);
    end
    #1 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (sram_cs !== 2'b11 || sram_clock !== 2'b00 || sram_sio_o !== 8'h00 || sram_sio_oe !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_pins: cs=%b clk=%b sio_o=%h oe=%h required 11/00/00/00", sram_cs, sram_clock, sram_sio_o, sram_sio_oe);
    end
    checks++;
    if (gnt !== 3'b000 || owner !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_ctrl: gnt=%b owner=%0d busy=%b required 000/0/0", gnt, owner, busy);
    end
    cycle(); cycle();
    req = 3'b000;
    reset = 1'b1;
    cycle();
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: gnt=%b required 000", gnt);
    end
    req = 3'b001;
    cycle();
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("[TB] FAIL post_reset_grant: gnt=%b required 001", gnt);
    end
    req = 3'b000;
    for (int i = 0; i <= G; i++) cycle();
  endtask

  task automatic test_random();
    logic [2:0]   exp_gnt;
    logic [C-1:0] exp_cs, exp_clk;
    logic [W-1:0] exp_o, exp_oe;
    logic [2:0]   prev_gnt;
    int           zero_run;
    bit           seen;
    prev_gnt = gnt;
    seen = (gnt != 3'b000);
    zero_run = 0;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(7) == 0) req = 3'($urandom);
      abort_clr = ($urandom_range(15) == 0);
      apply_stimulus_pins();
      cycle();
      exp_gnt = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
      if (m_owner == 0) begin
        exp_cs = '1; exp_clk = '0; exp_o = '0; exp_oe = '0;
      end else begin
        exp_cs  = rq_cs[(m_owner-1)*C +: C];
        exp_clk = rq_sclk[(m_owner-1)*C +: C];
        exp_o   = rq_sio_o[(m_owner-1)*W +: W];
        exp_oe  = rq_sio_oe[(m_owner-1)*W +: W];
      end
      checks++;
      if (gnt !== exp_gnt || owner !== 2'(m_owner)) begin
        errors++;
        $display("[TB] FAIL rand_grant: cycle %0d gnt=%b owner=%0d required %b/%0d", n, gnt, owner, exp_gnt, m_owner);
      end
      checks++;
      if (busy !== (m_owner != 0 || m_guard > 0) || abort !== m_abort) begin
        errors++;
        $display("[TB] FAIL rand_status: cycle %0d busy=%b abort=%b required %b/%b", n, busy, abort, (m_owner != 0 || m_guard > 0), m_abort);
      end
      checks++;
      if (sram_cs !== exp_cs || sram_clock !== exp_clk || sram_sio_o !== exp_o || sram_sio_oe !== exp_oe) begin
        errors++;
        $display("[TB] FAIL rand_pins: cycle %0d cs=%b clk=%b o=%h oe=%h required %b/%b/%h/%h", n, sram_cs, sram_clock, sram_sio_o, sram_sio_oe, exp_cs, exp_clk, exp_o, exp_oe);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("[TB] FAIL rand_onehot: cycle %0d gnt=%b required one-hot or zero", n, gnt);
      end
      if (gnt != 3'b000) begin
        checks++;
        if ((prev_gnt != 3'b000 && gnt != prev_gnt) || (prev_gnt == 3'b000 && seen && zero_run < G + 1)) begin
          errors++;
          $display("[TB] FAIL rand_gap: cycle %0d gap=%0d required at least %0d", n, zero_run, G + 1);
        end
        seen = 1;
        zero_run = 0;
      end else begin
        zero_run++;
      end
      prev_gnt = gnt;
    end
    abort_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_debug();
    test_priority();
    test_timeout();
    test_drop_at_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
